alu_issue_ctrl: RTL
===================

Name: alu_issue_ctrl

Overview:
Sequencer and two-requester arbiter in front of the shared combinational alu (integer/FP, 3-bit Op, is_fp select). Accepts operations from two issue ports over valid/ready, round-robin arbitrates, and holds alu operands stable for a per-class occupancy. Captures the alu Result and returns it on a single response port with requester ID and backpressure. One operation is in flight at a time.

Parameters:
INT_CYCLES, 1, cycles the alu inputs are held for an integer op (>=1)
FP_CYCLES, 4, cycles the alu inputs are held for an FP op before Result is sampled (>=1)
CNT_W, 3, width of occupancy counter; must hold max(INT_CYCLES,FP_CYCLES)-1

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req0_valid  in  1  requester 0 has an op
req0_ready  out  1  requester 0 op accepted this cycle (valid&ready)
req0_a  in  32  operand A
req0_b  in  32  operand B
req0_op  in  3  alu opcode
req0_is_fp  in  1  FP select
req1_valid / req1_ready / req1_a / req1_b / req1_op / req1_is_fp  same as requester 0
alu_a  out  32  to alu A
alu_b  out  32  to alu B
alu_op  out  3  to alu Op
alu_is_fp  out  1  to alu is_fp
alu_result  in  32  from alu Result
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_id  out  1  requester that issued the op
rsp_result  out  32  captured result
rsp_err  out  1  illegal FP opcode; rsp_result=0

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset: state=IDLE; alu_a/alu_b=0, alu_op=0, alu_is_fp=0; rsp_valid=0, rsp_id=0, rsp_result=0, rsp_err=0; req*_ready=0; last_grant=1 (req0 wins first contention).
- FSM IDLE -> EXEC -> RESP -> IDLE.
- IDLE: reqN_ready=1 combinationally only for the arbitration winner. Winner: only valid requester; if both valid, the one != last_grant. On accept: latch a/b/op/is_fp into operand regs (drive alu_* directly), latch id, update last_grant, cnt = (is_fp ? FP_CYCLES : INT_CYCLES)-1, go EXEC.
- Illegal FP op (is_fp=1, op not ADD/SUB/MUL): accepted normally, but go straight to RESP with rsp_err=1, rsp_result=0; alu_* regs unchanged.
- EXEC: readies=0. If cnt!=0 decrement; if cnt==0 register alu_result into rsp_result, rsp_err=0, go RESP.
- RESP: rsp_valid=1; rsp_id/result/err stable until handshake. rsp_valid&rsp_ready -> IDLE, rsp_valid=0. Readies 0 in RESP (no accept in the handshake cycle).
- Latency (INT_CYCLES=1): accept at cycle T, rsp_valid first high at T+2. General: T+1+occupancy.
- Throughput: at most one op per (occupancy+2) cycles with rsp_ready tied high.
- alu_* hold last operands in IDLE/RESP (no toggling when idle).
- Requester that drops valid before ready is simply not granted; no state change.
- rst mid-EXEC/RESP: immediate return to reset values; in-flight op discarded, no response.
- last_grant updates only on an accept, never on a response.

Decomposition:
- Shared package alu_pkg: opcode localparams/enum (OP_ADD=3'b000, OP_SUB=3'b001, OP_MUL=3'b010), FSM state enum, helper function is_legal_fp_op(op). alu already uses these encodings; migrate it to the package.
- Sub-module rr_arb2 (2-way round-robin with last_grant register, grant only on accept). Everything else flat.

Test Plan:
- req0: A=10,B=5,op=000,is_fp=0, rsp_ready=1 -> accept T, rsp_valid at T+2, rsp_result=15, rsp_id=0, rsp_err=0.
- req1: A=20,B=7,op=001,is_fp=0 -> rsp_result=13, rsp_id=1; alu_* stable throughout EXEC.
- FP: A=0x3f800000,B=0x40000000,op=000,is_fp=1, FP_CYCLES=4 -> rsp_valid at T+5, result 0x40400000; op=010 -> 0x40000000.
- Both valid continuously, 4 ops -> grants alternate 0,1,0,1; rsp_id sequence matches.
- rsp_ready held 0 for 6 cycles in RESP -> rsp_valid/result/id stable, no new accept; release -> IDLE next cycle, next accept the cycle after.
- FP op=011 -> rsp_err=1, rsp_result=0, rsp_valid at T+1. rst asserted in EXEC -> outputs at reset values within the same cycle, no response afterwards.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the alu and its issue controller: opcode encodings,
// the issue FSM state type and the FP opcode legality check.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // The FP datapath only implements add, subtract and multiply.
  function automatic logic is_legal_fp_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The grant is combinational; the priority
// pointer (last_grant) only advances when a grant is actually taken.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic valid0,
  input  logic valid1,
  output logic grant0,
  output logic grant1,
  output logic grant_id
);

  logic last_grant_q;
  logic last_grant_d;

  // Pick the winner: a lone requester wins, on contention the one that did not win last.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (en) begin
      if (valid0 && valid1) begin
        grant0 = last_grant_q;
        grant1 = !last_grant_q;
      end else begin
        grant0 = valid0;
        grant1 = valid1;
      end
    end
  end

  assign grant_id = grant1;

  // A grant is always taken (ready=grant, accept=valid&ready), so any grant moves the pointer.
  always_comb begin
    last_grant_d = last_grant_q;
    if (grant0 || grant1) begin
      last_grant_d = grant1;
    end
  end

  // Pointer register; reset to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue sequencer in front of the shared combinational alu: arbitrates two
// requesters, holds the alu operands for the op's occupancy, captures the
// result and returns it on a single backpressured response port.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int INT_CYCLES = 1,
  parameter int FP_CYCLES  = 4,
  parameter int CNT_W      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_op,
  input  logic        req0_is_fp,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_op,
  input  logic        req1_is_fp,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  output logic        alu_is_fp,
  input  logic [31:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_err
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        alu_a_q, alu_a_d;
  logic [31:0]        alu_b_q, alu_b_d;
  logic [2:0]         alu_op_q, alu_op_d;
  logic               alu_is_fp_q, alu_is_fp_d;
  logic               id_q, id_d;
  logic [31:0]        rsp_result_q, rsp_result_d;
  logic               rsp_err_q, rsp_err_d;

  logic               arb_en;
  logic               grant0, grant1, grant_id;
  logic               accept;
  logic [31:0]        sel_a, sel_b;
  logic [2:0]         sel_op;
  logic               sel_is_fp;
  logic               sel_illegal;

  // Ready is offered only while idle; gating with rst keeps readies low during reset.
  assign arb_en = (state_q == ST_IDLE) && !rst;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .en       (arb_en),
    .valid0   (req0_valid),
    .valid1   (req1_valid),
    .grant0   (grant0),
    .grant1   (grant1),
    .grant_id (grant_id)
  );

  assign accept      = grant0 || grant1;
  assign sel_a       = grant_id ? req1_a     : req0_a;
  assign sel_b       = grant_id ? req1_b     : req0_b;
  assign sel_op      = grant_id ? req1_op    : req0_op;
  assign sel_is_fp   = grant_id ? req1_is_fp : req0_is_fp;
  assign sel_illegal = sel_is_fp && !is_legal_fp_op(sel_op);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: illegal FP ops skip the alu and answer immediately.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = sel_illegal ? ST_RESP : ST_EXEC;
      ST_EXEC: if (cnt_q == '0) state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: handshake signals only.
  always_comb begin
    req0_ready = grant0;
    req1_ready = grant1;
    rsp_valid  = (state_q == ST_RESP);
  end

  // Datapath: latch operands on accept, count occupancy, capture the result.
  always_comb begin
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    alu_is_fp_d  = alu_is_fp_q;
    id_d         = id_q;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          id_d  = grant_id;
          cnt_d = sel_is_fp ? CNT_W'(FP_CYCLES - 1) : CNT_W'(INT_CYCLES - 1);
          if (sel_illegal) begin
            rsp_err_d    = 1'b1;
            rsp_result_d = '0;
          end else begin
            alu_a_d     = sel_a;
            alu_b_d     = sel_b;
            alu_op_d    = sel_op;
            alu_is_fp_d = sel_is_fp;
          end
        end
      end
      ST_EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          rsp_result_d = alu_result;
          rsp_err_d    = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; an in-flight op is dropped on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      alu_is_fp_q  <= 1'b0;
      id_q         <= 1'b0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      alu_is_fp_q  <= alu_is_fp_d;
      id_q         <= id_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign alu_is_fp  = alu_is_fp_q;
  assign rsp_id     = id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_err    = rsp_err_q;

endmodule
